// File: rtl/spi_mem_writer.sv
// Packs an SPI byte stream little-endian into 32-bit words and writes them to on-chip RAM.
// All outputs registered; one write cycle per word (no waitrequest), 4 bytes / 5 cycles peak.
module spi_mem_writer #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH_WORDS = 10000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len_words,
  input  logic                  flush,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [3:0]            byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [31:0]           writedata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(DEPTH_WORDS);

  state_t                state_q;
  logic [1:0]            byte_idx_q;
  logic                  final_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] word_count_q;
  logic                  overflow_q;
  logic [31:0]           writedata_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [3:0]            byteenable_q;
  logic                  cs_q;
  logic                  s_ready_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  accept;
  logic [2:0]            fill_cnt_d;
  logic [31:0]           writedata_d;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [ADDR_WIDTH-1:0] word_count_d;

  always_comb begin
    accept      = (state_q == FILL) && s_valid && s_ready_q;
    fill_cnt_d  = {1'b0, byte_idx_q} + {2'b00, accept};
    writedata_d = writedata_q;
    if (accept) writedata_d[8*byte_idx_q +: 8] = s_data;
    addr_sum    = {1'b0, base_q} + {1'b0, word_count_q};
    address_d   = (addr_sum >= DEPTH) ? ADDR_WIDTH'(addr_sum - DEPTH) : addr_sum[ADDR_WIDTH-1:0];
    word_count_d = word_count_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      final_q      <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      writedata_q  <= '0;
      address_q    <= '0;
      byteenable_q <= '0;
      cs_q         <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cs_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q       <= base_addr;
            len_q        <= len_words;
            word_count_q <= '0;
            byte_idx_q   <= '0;
            overflow_q   <= 1'b0;
            writedata_q  <= '0;
            final_q      <= 1'b0;
            if (len_words == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= FILL;
              busy_q    <= 1'b1;
              s_ready_q <= 1'b1;
            end
          end else if (s_valid) begin
            overflow_q <= 1'b1;
          end
        end
        FILL: begin
          writedata_q <= writedata_d;
          byte_idx_q  <= fill_cnt_d[1:0];
          // A byte arriving with flush is merged first; a completed word then writes full.
          if (fill_cnt_d == 3'd4 || (flush && fill_cnt_d != 3'd0)) begin
            state_q      <= WRITE;
            s_ready_q    <= 1'b0;
            cs_q         <= 1'b1;
            address_q    <= address_d;
            final_q      <= flush;
            byteenable_q <= (fill_cnt_d == 3'd4) ? 4'b1111 : (4'd1 << fill_cnt_d) - 4'd1;
          end else if (flush) begin
            state_q   <= DONE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        WRITE: begin
          byteenable_q <= '0;
          word_count_q <= word_count_d;
          byte_idx_q   <= '0;
          if (final_q || word_count_d == len_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= FILL;
            s_ready_q   <= 1'b1;
            writedata_q <= '0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign chipselect = cs_q;
  assign write      = cs_q;
  assign writedata  = writedata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_mem_writer.sv
// Scoreboarded bench for spi_mem_writer: expected RAM writes queued with stimulus, popped on chipselect.
module tb_spi_mem_writer;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len_words = '0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic          busy;
  logic          done;
  logic [AW-1:0] word_count;
  logic          overflow;

  spi_mem_writer #(.ADDR_WIDTH(AW), .DEPTH_WORDS(10000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .len_words(len_words), .flush(flush), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata),
    .busy(busy), .done(done), .word_count(word_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Scoreboard: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && done) done_cnt++;
    if (reset_n && chipselect) begin
      wr_t exp_w;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h be=%b, required no write", address, writedata, byteenable);
      end else begin
        exp_w = sb.pop_front();
        if ({address, writedata, byteenable, write} !== {exp_w.addr, exp_w.data, exp_w.be, 1'b1}) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h be=%b wr=%b, required addr=%0d data=%h be=%b wr=1",
                   address, writedata, byteenable, write, exp_w.addr, exp_w.data, exp_w.be);
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1; base_addr = b; len_words = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes();
    while (tx_q.size() > 0) begin
      int n = 0;
      s_valid = 1'b1;
      s_data  = tx_q.pop_front();
      while (!s_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL s_ready_timeout: got s_ready=0 for 50 cycles, required 1");
        tx_q.delete();
      end else begin
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [AW-1:0] exp_wc);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout: got done=0, required 1", name);
    end else if ({busy, word_count} !== {1'b0, exp_wc}) begin
      errors++;
      $display("FAIL %s_end: got busy=%b word_count=%0d, required busy=0 word_count=%0d", name, busy, word_count, exp_wc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got done=%b after one cycle, required 0", name, done);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({s_ready, address, byteenable, chipselect, write, writedata, busy, done, word_count, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got s_ready=%b cs=%b busy=%b done=%b wc=%0d ovf=%b data=%h, required all 0",
               s_ready, chipselect, busy, done, word_count, overflow, writedata);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_words();
    int d0 = done_cnt;
    do_start(14'd0, 14'd2);
    checks++;
    if ({busy, s_ready} !== 2'b11) begin
      errors++;
      $display("FAIL start_latency: got busy=%b s_ready=%b, required 1 1", busy, s_ready);
    end
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sb.push_back('{addr: 14'd0, data: 32'h44332211, be: 4'b1111});
    sb.push_back('{addr: 14'd1, data: 32'h88776655, be: 4'b1111});
    send_bytes();
    wait_done("two_words", 14'd2);
    check_sb_empty("two_words");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL two_words_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_partial_flush();
    do_start(14'd5, 14'd4);
    tx_q = '{8'hAA, 8'hBB};
    sb.push_back('{addr: 14'd5, data: 32'h0000BBAA, be: 4'b0011});
    send_bytes();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_done("partial_flush", 14'd1);
    check_sb_empty("partial_flush");
  endtask

  task automatic test_wrap();
    logic [7:0] b[12];
    do_start(14'd9998, 14'd3);
    for (int i = 0; i < 12; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      tx_q.push_back(b[i]);
    end
    for (int w = 0; w < 3; w++)
      sb.push_back('{addr: (w == 2) ? 14'd0 : 14'(9998 + w),
                     data: {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}, be: 4'b1111});
    send_bytes();
    wait_done("wrap", 14'd3);
    check_sb_empty("wrap");
  endtask

  task automatic test_len0_overflow();
    do_start(14'd7, 14'd0);
    checks++;
    if ({done, busy, s_ready} !== 3'b100) begin
      errors++;
      $display("FAIL len0_done: got done=%b busy=%b s_ready=%b, required 1 0 0", done, busy, s_ready);
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h5A;
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b, required 1", overflow);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b, required 1", overflow);
    end
    do_start(14'd3, 14'd1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b, required 0", overflow);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_done("empty_flush", 14'd0);
    check_sb_empty("len0_overflow");
  endtask

  task automatic test_flush_coincident();
    do_start(14'd20, 14'd4);
    tx_q = '{8'h01, 8'h02, 8'h03};
    sb.push_back('{addr: 14'd20, data: 32'h04030201, be: 4'b1111});
    send_bytes();
    s_valid = 1'b1; s_data = 8'h04; flush = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({chipselect, write} !== 2'b11) begin
      errors++;
      $display("FAIL coincident_strobe: got cs=%b wr=%b, required 1 1", chipselect, write);
    end
    wait_done("flush_coincident", 14'd1);
    check_sb_empty("flush_coincident");
  endtask

  task automatic test_reset_mid_fill();
    do_start(14'd0, 14'd2);
    tx_q = '{8'hC1, 8'hC2};
    send_bytes();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, address, byteenable, chipselect, write, writedata, busy, done, word_count, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: got s_ready=%b cs=%b busy=%b wc=%0d data=%h, required all 0",
               s_ready, chipselect, busy, word_count, writedata);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check_sb_empty("reset_mid_fill");
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_partial_flush();
    test_wrap();
    test_len0_overflow();
    test_flush_coincident();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
